uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Parametrised UART transmitter with a small input FIFO. It supports configurable data width, parity mode, stop-bit count and a fixed baud divisor. Host logic pushes words over a valid/ready handshake, and the block serialises them LSB-first on `tx` with no idle gap between queued frames. It sits between the command/response logic and the board TX pin.

## Interface
- `CLOCK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate. `BIT_PERIOD = CLOCK_FREQ / BAUD_RATE` (integer divide) must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: input FIFO entries, a power of 2 and ≥ 2.

Ports:
- `clk` in 1: system clock. All logic is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `s_valid` in 1: a word is offered on `s_data`.
- `s_ready` out 1: the FIFO can accept a word.
- `s_data` in `DATA_BITS`: word to transmit.
- `tx` out 1: serial line, registered, idle high.
- `busy` out 1: a frame is in progress.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: number of queued words, excluding the one being shifted.

## Operation
- **Push.** A push occurs on a rising edge where `s_valid && s_ready`. `s_ready = (fifo_count != FIFO_DEPTH)`. It is full-based only: a pop in the same cycle does not raise it.
- **Data ordering.** There is no bypass path. Every word passes through the FIFO. Data is taken from `s_data` at the push edge.
- **States.**
  - IDLE:
    - `tx = 1`, `busy = 0`.
    - If the FIFO is non-empty: pop into the shifter, compute parity, go to START.
  - START:
    - `tx = 0` for `BIT_PERIOD` cycles, then go to DATA.
  - DATA:
    - `tx = shifter[0]`.
    - Each bit lasts `BIT_PERIOD` cycles. Shift right at the end of each bit.
    - After bit `DATA_BITS-1`, go to PARITY if `PARITY != 0`, otherwise STOP.
  - PARITY:
    - `tx` = parity bit for `BIT_PERIOD` cycles, then go to STOP.
    - Odd mode: the total count of ones over data + parity is odd.
    - Even mode: that total is even.
  - STOP:
    - `tx = 1` for `STOP_BITS*BIT_PERIOD` cycles.
    - On the final cycle, if the FIFO is non-empty: pop and go directly to START. This gives back-to-back frames.
    - Otherwise go to IDLE.
- **Frame length.** `1 + DATA_BITS + (PARITY!=0) + STOP_BITS` bit periods.
- **Counters.**
  - Bit-time counter: `$clog2(STOP_BITS*BIT_PERIOD)` bits, cleared at every state change.
  - Bit index: `$clog2(DATA_BITS)` bits.
  - Neither counter wraps outside these rules.
- **Reset** (asynchronous, any time, including mid-frame):
  - `tx = 1`, `busy = 0`, `s_ready = 1`, `fifo_count = 0`.
  - FIFO is emptied and state returns to IDLE.
  - A partial frame is abandoned. No completion is signalled.
- **Illegal parameters.** Illegal `DATA_BITS`, `PARITY`, `STOP_BITS` or `BIT_PERIOD` values stop elaboration via a generate-time check.

## Timing
- **Push into an idle block with an empty FIFO.** The push occurs at edge E. The pop and the START entry occur at edge E+1. `tx` falls at E+1.
- **Bit lengths.** Each start, data and parity bit is held exactly `BIT_PERIOD` cycles. The stop interval is exactly `STOP_BITS*BIT_PERIOD` cycles.
- **Back-to-back frames.** The next start bit begins on the cycle immediately after the last stop cycle, with zero idle cycles.
- **`busy`.** Registered. It goes high at the same edge as the START entry and goes low at the edge returning to IDLE.
- **`fifo_count`.**
  - Increments on a push.
  - Decrements on a pop.
  - Unchanged on a simultaneous push and pop.
- **`s_ready`.** Falls the cycle after the push that fills the FIFO. Rises the cycle after the pop that frees an entry.

## Structure
- **Package `uart_pkg`:**
  - Parity constants `PARITY_NONE`, `PARITY_ODD`, `PARITY_EVEN`.
  - State encoding for IDLE/START/DATA/PARITY/STOP.
  - Function `bit_period(clock_freq, baud_rate)`.
- **Sub-module `uart_sync_fifo`:**
  - Parameters `WIDTH` and `DEPTH`.
  - Ports: push, pop, data in/out, count, full, empty.
  - Registered storage, wrap-around pointers with an extra MSB.
  - Reused later by the RX side.
- **Top level:** the FSM, bit counters, shifter and parity all live in `uart_tx_cfg`.

## Test plan
All scenarios use `CLOCK_FREQ = 1_000_000` and `BAUD_RATE = 100_000`, giving `BIT_PERIOD = 10`.

- **Defaults, single word.** Push `0xA5`. `tx` low at E+1 for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10. `busy` high for 100 cycles total.
- **`DATA_BITS = 7`, even parity, `STOP_BITS = 2`.** Push `7'h55` (four ones). Expect start, 1010101, parity 0, then 20 cycles of high. Total frame 110 cycles.
- **Odd parity, `DATA_BITS = 8`, ones count 0.** Push `0x00`. Parity bit = 1.
- **Fill, then back-to-back.**
  - Push 5 words back-to-back at defaults.
  - `fifo_count` peaks at 4 and `s_ready` drops at 4.
  - The 5th word is accepted once the first pop frees an entry.
  - The five frames are contiguous: exactly 500 cycles from the first start edge to the last stop end, with no high gap beyond the stop bits.
- **Simultaneous push and pop.** With `fifo_count = 2`, push on the stop-end pop cycle. `fifo_count` stays 2.
- **Reset mid-frame.**
  - Assert `reset` asynchronously during data bit 3 with 2 words queued.
  - `tx` goes to 1 immediately; `busy = 0`, `fifo_count = 0`, `s_ready = 1`.
  - After release, no frame is emitted until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and baud helper
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  function automatic int bit_period(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with extra-MSB wrap-around pointers
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointer MSBs differ only when the write side has lapped the read side.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parametrised UART transmitter fed by a small input FIFO
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BIT_PERIOD = bit_period(CLOCK_FREQ, BAUD_RATE);
  localparam int STOP_LEN   = STOP_BITS * BIT_PERIOD;
  localparam int CW         = $clog2(STOP_LEN);
  localparam int IW         = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 ||
        (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        BIT_PERIOD < 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("uart_tx_cfg: illegal parameter combination");
    end
  endgenerate

  tx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q;

  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bit_done;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == PARITY_ODD) ? ~^d : ^d;
  endfunction

  assign s_ready = !fifo_full;
  assign push    = s_valid && s_ready;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (s_data),
    .rd_data (fifo_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    pop      = 1'b0;
    bit_done = (cnt_q == BIT_LAST);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          par_d   = calc_parity(fifo_data);
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d = '0;
          // Popping on the last stop cycle chains frames with no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            par_d   = calc_parity(fifo_data);
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // tx is registered, so it is derived from the state being entered.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       s_valid0, s_ready0, tx0, busy0;
  logic [7:0] s_data0;
  logic [2:0] fifo_count0;
  logic       s_valid1, s_ready1, tx1, busy1;
  logic [6:0] s_data1;
  logic [2:0] fifo_count1;
  logic       s_valid2, s_ready2, tx2, busy2;
  logic [7:0] s_data2;
  logic [2:0] fifo_count2;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  int         peak;
  bit         saw_full;
  logic [2:0] last_cnt;

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut0 (
    .clk(clk), .reset(reset), .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
    .tx(tx0), .busy(busy0), .fifo_count(fifo_count0));

  uart_tx_cfg #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .tx(tx1), .busy(busy1), .fifo_count(fifo_count1));

  uart_tx_cfg #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(1)) dut2 (
    .clk(clk), .reset(reset), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .tx(tx2), .busy(busy2), .fifo_count(fifo_count2));

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [1:0] obs(input int d);
    case (d)
      0:       return {busy0, tx0};
      1:       return {busy1, tx1};
      default: return {busy2, tx2};
    endcase
  endfunction

  function automatic logic [11:0] f8n1(input logic [7:0] w);
    return {3'b001, w, 1'b0};
  endfunction

  // Advance one cycle; offers the head of q to dut0, dropping it once accepted.
  task automatic feed_and_tick();
    bit take;
    take = s_valid0 && s_ready0;
    @(negedge clk);
    if (take) void'(q.pop_front());
    if (q.size() > 0) begin
      s_valid0 = 1'b1;
      s_data0  = q[0];
    end else begin
      s_valid0 = 1'b0;
    end
    if (int'(fifo_count0) > peak) peak = int'(fifo_count0);
    if (!s_ready0) saw_full = 1'b1;
  endtask

  task automatic check_frame(input int d, input logic [11:0] bits, input int nbits,
                             input string tag, input int inject_at, input logic [7:0] inject_w);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 10; c++) begin
        check($sformatf("%s bit%0d cyc%0d", tag, b, c), obs(d), {1'b1, bits[b]});
        if (b == nbits - 1 && c == 9) last_cnt = fifo_count0;
        if (b * 10 + c == inject_at) q.push_back(inject_w);
        feed_and_tick();
      end
    end
  endtask

  initial begin
    s_valid0 = 1'b0; s_data0 = '0;
    s_valid1 = 1'b0; s_data1 = '0;
    s_valid2 = 1'b0; s_data2 = '0;
    peak = 0; saw_full = 1'b0; last_cnt = '0;

    @(negedge clk);
    check("rst_tx", tx0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_ready", {s_ready0, s_ready1, s_ready2}, 3'b111);
    check("rst_count", fifo_count0, 3'd0);
    check("rst_tx12", {tx1, tx2}, 2'b11);
    reset = 1'b0;
    @(negedge clk);

    // Single 0xA5 at defaults
    q.push_back(8'hA5);
    feed_and_tick();
    feed_and_tick();
    check("a5_pushed_idle", obs(0), 2'b01);
    check("a5_pushed_count", fifo_count0, 3'd1);
    feed_and_tick();
    check("a5_popped_count", fifo_count0, 3'd0);
    check_frame(0, f8n1(8'hA5), 10, "a5", -1, 8'h00);
    check("a5_idle", obs(0), 2'b01);

    // 7 data bits, even parity, two stop bits
    s_valid1 = 1'b1; s_data1 = 7'h55;
    @(negedge clk);
    s_valid1 = 1'b0;
    check("7e2_count", fifo_count1, 3'd1);
    check("7e2_pre", obs(1), 2'b01);
    @(negedge clk);
    check_frame(1, {2'b11, 1'b0, 7'h55, 1'b0}, 11, "7e2", -1, 8'h00);
    check("7e2_idle", obs(1), 2'b01);

    // Odd parity over all-zero data
    s_valid2 = 1'b1; s_data2 = 8'h00;
    @(negedge clk);
    s_valid2 = 1'b0;
    check("8o1_count", fifo_count2, 3'd1);
    @(negedge clk);
    check_frame(2, {1'b1, 1'b1, 8'h00, 1'b0}, 11, "8o1", -1, 8'h00);
    check("8o1_idle", obs(2), 2'b01);

    // Fill the FIFO, then five contiguous frames
    peak = 0; saw_full = 1'b0;
    q = '{8'h3C, 8'h81, 8'hFF, 8'h00, 8'h5A};
    feed_and_tick();
    feed_and_tick();
    feed_and_tick();
    check_frame(0, f8n1(8'h3C), 10, "fill0", -1, 8'h00);
    check("fill_peak", peak, 4);
    check("fill_saw_full", saw_full, 1'b1);
    check("fill_all_accepted", q.size(), 0);
    check("fill_count_after_pop", fifo_count0, 3'd3);
    check("fill_ready_after_pop", s_ready0, 1'b1);
    check_frame(0, f8n1(8'h81), 10, "fill1", -1, 8'h00);
    check_frame(0, f8n1(8'hFF), 10, "fill2", -1, 8'h00);
    check_frame(0, f8n1(8'h00), 10, "fill3", -1, 8'h00);
    check_frame(0, f8n1(8'h5A), 10, "fill4", -1, 8'h00);
    check("fill_idle", obs(0), 2'b01);
    check("fill_count_end", fifo_count0, 3'd0);

    // Push lands on the stop-end pop edge with two words queued
    q = '{8'h11, 8'h22, 8'h33};
    feed_and_tick();
    feed_and_tick();
    feed_and_tick();
    check_frame(0, f8n1(8'h11), 10, "sp0", 98, 8'h44);
    check("sp_count_before", last_cnt, 3'd2);
    check("sp_count_after", fifo_count0, 3'd2);
    check_frame(0, f8n1(8'h22), 10, "sp1", -1, 8'h00);
    check_frame(0, f8n1(8'h33), 10, "sp2", -1, 8'h00);
    check_frame(0, f8n1(8'h44), 10, "sp3", -1, 8'h00);
    check("sp_idle", obs(0), 2'b01);

    // Asynchronous reset during data bit 3 with two words queued
    q = '{8'h66, 8'h77, 8'h88};
    feed_and_tick();
    feed_and_tick();
    feed_and_tick();
    for (int i = 0; i < 45; i++) feed_and_tick();
    check("mid_pre_tx", obs(0), 2'b10);
    check("mid_pre_count", fifo_count0, 3'd2);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_tx", tx0, 1'b1);
    check("mid_rst_busy", busy0, 1'b0);
    check("mid_rst_count", fifo_count0, 3'd0);
    check("mid_rst_ready", s_ready0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      check($sformatf("post_rst_quiet%0d", i), {obs(0), fifo_count0}, {2'b01, 3'd0});
      feed_and_tick();
    end
    q.push_back(8'h99);
    feed_and_tick();
    feed_and_tick();
    feed_and_tick();
    check_frame(0, f8n1(8'h99), 10, "post_rst", -1, 8'h00);
    check("post_rst_idle", obs(0), 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
